uart_byte_txrx: RTL and testbench
=================================

# uart_byte_txrx

Byte-level UART physical layer with an independent transmitter and receiver that share one clock and reset. It serializes and deserializes 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) at a fixed, parameterised baud rate. It sits below the Modbus RTU framing logic, which uses `rx_done` and `rx_state` for byte delivery and inter-character (1.5T/3.5T) timing.

## Interface
- `CLK_FREQ`, default 50000000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in baud. Bit period `BAUD_DIV = CLK_FREQ/BAUD_RATE`, integer-truncated (434 at defaults).
- `sys_clk` input, 1 bit: system clock; all logic on the rising edge.
- `reset_n` input, 1 bit: reset, asynchronous, active-low.
- `tx_start` input, 1 bit: transmit request; acts on its rising edge only.
- `tx_data` input, 8 bits: byte to send; captured on the accepted start edge.
- `tx_done` output, 1 bit: one-cycle pulse at end of stop bit.
- `tx_state` output, 1 bit: high while a frame is being sent.
- `rs232_tx` output, 1 bit: serial line out; idle high.
- `rs232_rx` input, 1 bit: serial line in; asynchronous.
- `rx_data` output, 8 bits: last correctly framed byte received.
- `rx_done` output, 1 bit: one-cycle pulse when `rx_data` updates.
- `rx_state` output, 1 bit: high while a frame is being received.

## Operation
- Reset values: `rs232_tx`=1, `tx_done`=0, `tx_state`=0, `rx_data`=8'h00, `rx_done`=0, `rx_state`=0. All counters, state registers and synchronizers clear; synchronizer flops reset to 1.
- Reset asserted mid-frame aborts both paths immediately.

**TX**
- Edge detect: register `tx_start`; start = `tx_start & ~tx_start_d`.
- Idle with start: latch `tx_data` and set `tx_state`=1.
- Drive 10 bit slots of `BAUD_DIV` cycles each: 0, d[0]..d[7], 1.
- At the last cycle of the stop slot: `tx_done`=1 for one cycle, `tx_state`=0, line stays 1.
- Start edges while `tx_state`=1 are ignored.
- `tx_data` changes during a frame have no effect.

**RX**
- `rs232_rx` passes through a 2-flop synchronizer, then a falling-edge detector.
- States:
  - IDLE: on a falling edge, go to START and set `rx_state`=1.
  - START: sample at `BAUD_DIV/2` cycles (217 at defaults). If the sample is 1, it is a false start: go to IDLE and set `rx_state`=0.
  - DATA: 8 samples, one every `BAUD_DIV`, shifted in LSB first.
  - STOP: sample at the stop-bit centre.
    - Stop = 1: load `rx_data` and pulse `rx_done` for one cycle.
    - Stop = 0 (framing error): no pulse; `rx_data` is unchanged.
    - In both cases `rx_state`=0 and go to IDLE the same cycle.
- Because RX returns to IDLE at the stop-bit centre, it catches a start bit that immediately follows.

## Timing
- TX: start edge sampled at clock N; `rs232_tx` falls at N+1.
- TX: `tx_done` asserts at N+10·`BAUD_DIV` (4340 cycles at defaults).
- TX: a new start edge is accepted in the cycle after `tx_done`, so back-to-back frames are gapless.
- RX: `rx_done` asserts about 2 sync cycles + 9.5·`BAUD_DIV` after the line's falling edge.
- Bit-centre counters are exact integer counts; no fractional-baud compensation.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each RX sample (start, data, stop) is the 2-of-3 majority of the synchronized line at centre−1, centre and centre+1 cycles. The decision is taken at centre+1, so `rx_done` is one cycle later.
- `UART_RX_MAJORITY_EN` undefined: single sample at the exact centre cycle.

## Test plan
- Loopback (`rs232_tx`→`rs232_rx`), defaults: send 8'hC2, 8'hB3, 8'hA4, 8'h95 back-to-back, each start issued the cycle after the previous `tx_done`. Required: four `rx_done` pulses with `rx_data` = C2, B3, A4, 95 in order, and no idle gap on `rs232_tx`.
- Single 1-cycle `tx_start` pulse with 8'hAA. Required:
  - `tx_done` pulse exactly 4340 cycles after the sampled edge.
  - `tx_state` high throughout the frame.
  - Line pattern 0,0,1,0,1,0,1,0,1,1, each slot 434 cycles.
- Second `tx_start` edge 1000 cycles into a frame. Required: ignored; exactly one frame sent and one `tx_done` pulse.
- `rs232_rx` low glitch of 100 cycles. Required: `rx_state` pulses briefly, no `rx_done`, `rx_data` unchanged.
- Inject 8'h55 with stop bit = 0. Required: no `rx_done`, `rx_data` holds its previous value; a following valid 8'h3C is received correctly.
- Assert `reset_n`=0 mid-frame on both paths. Required: `rs232_tx`=1, `tx_state`=`rx_state`=0, `rx_data`=0; next frame after release works normally.

Source files
------------

// File: rtl/uart_byte_txrx.sv
// uart_byte_txrx: byte-level 8N1 UART physical layer with independent
// transmitter and receiver sharing one clock and reset.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  line rate; bit period BAUD_DIV = CLK_FREQ / BAUD_RATE (truncated)
//
// Ports
//   sys_clk   in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   tx_start  in   transmit request, acts on its rising edge only
//   tx_data   in   byte to send, captured on the accepted start edge
//   tx_done   out  one-cycle pulse in the last cycle of the stop bit
//   tx_state  out  high while a frame is being sent
//   rs232_tx  out  serial line out, idle high
//   rs232_rx  in   serial line in, asynchronous
//   rx_data   out  last correctly framed byte received
//   rx_done   out  one-cycle pulse when rx_data updates
//   rx_state  out  high while a frame is being received
//
// Build option
//   UART_RX_MAJORITY_EN  when defined, every RX sample is the 2-of-3 majority
//                        of the synchronized line at centre-1/centre/centre+1,
//                        decided at centre+1 (rx_done one cycle later).

module uart_byte_txrx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx_state,
    output logic       rs232_tx,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_state
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_DIV = BAUD_DIV / 2;
    localparam int unsigned CNT_W    = $clog2(BAUD_DIV + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned SAMPLE_LAG = 1;
`else
    localparam int unsigned SAMPLE_LAG = 0;
`endif
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BAUD_DIV - 1);
    // Decision cycle of the start bit, counted from the cycle after the falling edge.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF_DIV - 1 + SAMPLE_LAG);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_fsm_t;

    tx_fsm_t          r_tx_fsm;
    tx_fsm_t          w_tx_fsm_nxt;
    logic             r_tx_start_d;
    logic             w_tx_start_edge;
    logic [9:0]       r_tx_frame;
    logic [9:0]       w_tx_frame_nxt;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [CNT_W-1:0] w_tx_cnt_nxt;
    logic [3:0]       r_tx_bit;
    logic [3:0]       w_tx_bit_nxt;
    logic             r_tx_line;
    logic             w_tx_line_nxt;
    logic             r_tx_done;
    logic             w_tx_done_nxt;
    logic             r_tx_busy;
    logic             w_tx_busy_nxt;

    assign w_tx_start_edge = tx_start & ~r_tx_start_d;

    // TX state and datapath registers
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_fsm     <= TX_IDLE;
            r_tx_start_d <= 1'b0;
            r_tx_frame   <= '0;
            r_tx_cnt     <= '0;
            r_tx_bit     <= '0;
            r_tx_line    <= 1'b1;
            r_tx_done    <= 1'b0;
            r_tx_busy    <= 1'b0;
        end else begin
            r_tx_fsm     <= w_tx_fsm_nxt;
            r_tx_start_d <= tx_start;
            r_tx_frame   <= w_tx_frame_nxt;
            r_tx_cnt     <= w_tx_cnt_nxt;
            r_tx_bit     <= w_tx_bit_nxt;
            r_tx_line    <= w_tx_line_nxt;
            r_tx_done    <= w_tx_done_nxt;
            r_tx_busy    <= w_tx_busy_nxt;
        end
    end

    // TX next state: frame bit k is driven for BAUD_DIV cycles, bit 0 = start
    always_comb begin
        w_tx_fsm_nxt   = r_tx_fsm;
        w_tx_frame_nxt = r_tx_frame;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_line_nxt  = r_tx_line;
        w_tx_done_nxt  = 1'b0;
        w_tx_busy_nxt  = r_tx_busy;
        case (r_tx_fsm)
            TX_IDLE: begin
                w_tx_line_nxt = 1'b1;
                if (w_tx_start_edge) begin
                    w_tx_fsm_nxt   = TX_SEND;
                    w_tx_frame_nxt = {1'b1, tx_data, 1'b0};
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_busy_nxt  = 1'b1;
                end
            end
            TX_SEND: begin
                w_tx_line_nxt = r_tx_frame[r_tx_bit];
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_bit == 4'd9) begin
                        // Last cycle of the stop slot: release so a new edge is taken next cycle.
                        w_tx_fsm_nxt  = TX_IDLE;
                        w_tx_done_nxt = 1'b1;
                        w_tx_busy_nxt = 1'b0;
                        w_tx_line_nxt = 1'b1;
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 4'd1;
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_tx_fsm_nxt = TX_IDLE;
            end
        endcase
    end

    assign tx_done  = r_tx_done;
    assign tx_state = r_tx_busy;
    assign rs232_tx = r_tx_line;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_fsm_t;

    rx_fsm_t          r_rx_fsm;
    rx_fsm_t          w_rx_fsm_nxt;
    logic             r_rx_s1;
    logic             r_rx_s2;
    logic             r_rx_s3;
    logic             w_rx_fall;
    logic             w_rx_bit;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [CNT_W-1:0] w_rx_cnt_nxt;
    logic [2:0]       r_rx_bits;
    logic [2:0]       w_rx_bits_nxt;
    logic [7:0]       r_rx_shift;
    logic [7:0]       w_rx_shift_nxt;
    logic [7:0]       r_rx_data;
    logic [7:0]       w_rx_data_nxt;
    logic             r_rx_done;
    logic             w_rx_done_nxt;
    logic             r_rx_busy;
    logic             w_rx_busy_nxt;

    // r_rx_s1/r_rx_s2 synchronize; r_rx_s3 is the previous synchronized value.
    assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

`ifdef UART_RX_MAJORITY_EN
    logic r_rx_s4;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_s4 <= 1'b1;
        end else begin
            r_rx_s4 <= r_rx_s3;
        end
    end

    // At the decision cycle s2/s3/s4 hold centre+1, centre, centre-1.
    assign w_rx_bit = (r_rx_s2 & r_rx_s3) | (r_rx_s2 & r_rx_s4) | (r_rx_s3 & r_rx_s4);
`else
    assign w_rx_bit = r_rx_s2;
`endif

    // RX synchronizer, state and datapath registers
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_fsm   <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bits  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_done  <= 1'b0;
            r_rx_busy  <= 1'b0;
        end else begin
            r_rx_s1    <= rs232_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_rx_fsm   <= w_rx_fsm_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bits  <= w_rx_bits_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_done  <= w_rx_done_nxt;
            r_rx_busy  <= w_rx_busy_nxt;
        end
    end

    // RX next state: half-bit to the start centre, then one bit period per sample
    always_comb begin
        w_rx_fsm_nxt   = r_rx_fsm;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_bits_nxt  = r_rx_bits;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_data_nxt  = r_rx_data;
        w_rx_done_nxt  = 1'b0;
        w_rx_busy_nxt  = r_rx_busy;
        case (r_rx_fsm)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_fsm_nxt  = RX_START;
                    w_rx_cnt_nxt  = '0;
                    w_rx_busy_nxt = 1'b1;
                end
            end
            RX_START: begin
                if (r_rx_cnt == START_LAST) begin
                    w_rx_cnt_nxt = '0;
                    if (w_rx_bit) begin
                        // Line back high at the centre: glitch, not a start bit.
                        w_rx_fsm_nxt  = RX_IDLE;
                        w_rx_busy_nxt = 1'b0;
                    end else begin
                        w_rx_fsm_nxt  = RX_DATA;
                        w_rx_bits_nxt = '0;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {w_rx_bit, r_rx_shift[7:1]};
                    if (r_rx_bits == 3'd7) begin
                        w_rx_fsm_nxt = RX_STOP;
                    end else begin
                        w_rx_bits_nxt = r_rx_bits + 3'd1;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == BIT_LAST) begin
                    // Leave at the stop centre so an immediately following start is caught.
                    w_rx_cnt_nxt  = '0;
                    w_rx_fsm_nxt  = RX_IDLE;
                    w_rx_busy_nxt = 1'b0;
                    if (w_rx_bit) begin
                        w_rx_data_nxt = r_rx_shift;
                        w_rx_done_nxt = 1'b1;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_rx_fsm_nxt  = RX_IDLE;
                w_rx_busy_nxt = 1'b0;
            end
        endcase
    end

    assign rx_data  = r_rx_data;
    assign rx_done  = r_rx_done;
    assign rx_state = r_rx_busy;

endmodule

// File: tb/tb_uart_byte_txrx.sv
// Self-checking bench for uart_byte_txrx at default clock/baud.
// Expected frames come from the 8N1 rule (start 0, data LSB first, stop 1);
// received bytes are collected by a monitor and compared to a queue of sent bytes.

module tb_uart_byte_txrx;

    localparam int unsigned CLK_FREQ  = 50_000_000;
    localparam int unsigned BAUD_RATE = 115_200;
    localparam int unsigned BIT_T     = CLK_FREQ / BAUD_RATE;
    localparam int unsigned FRAME_T   = 10 * BIT_T;

    logic       sys_clk  = 1'b0;
    logic       reset_n  = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_done;
    logic       tx_state;
    logic       rs232_tx;
    logic       rs232_rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_state;

    logic        loopback = 1'b1;
    logic        rx_drv   = 1'b1;
    int unsigned n_vec    = 0;
    int unsigned n_err    = 0;
    logic [7:0]  rx_q[$];
    int unsigned tx_done_cnt = 0;
    logic [7:0]  exp_rx_data = 8'h00;

    assign rs232_rx = loopback ? rs232_tx : rx_drv;

    always #5 sys_clk = ~sys_clk;

    uart_byte_txrx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_done (tx_done),
        .tx_state(tx_state),
        .rs232_tx(rs232_tx),
        .rs232_rx(rs232_rx),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .rx_state(rx_state)
    );

    // Output monitor: log every received byte and count transmit completions.
    always @(negedge sys_clk) begin
        if (rx_done === 1'b1) rx_q.push_back(rx_data);
        if (tx_done === 1'b1) tx_done_cnt++;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    // Reference 8N1 frame: element 0 is the start bit.
    function automatic logic [9:0] frame_bits(input logic [7:0] d, input logic stop);
        return {stop, d, 1'b0};
    endfunction

    task automatic pulse_start(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    task automatic wait_tx_done(input int unsigned budget, output int unsigned waited, output bit seen);
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < budget) begin
            tick();
            waited++;
            if (tx_done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_rx_count(input int unsigned n, input int unsigned budget);
        int unsigned w = 0;
        while (rx_q.size() < n && w < budget) begin
            tick();
            w++;
        end
    endtask

    task automatic drive_rx_frame(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        fr = frame_bits(d, stop);
        for (int b = 0; b < 10; b++) begin
            rx_drv = fr[b];
            ticks(BIT_T);
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        loopback = 1'b1;
        ticks(3);
        n_vec++; if (rs232_tx !== 1'b1) begin n_err++; $display("FAIL reset_rs232_tx: got %b want 1", rs232_tx); end
        n_vec++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
        n_vec++; if (tx_state !== 1'b0) begin n_err++; $display("FAIL reset_tx_state: got %b want 0", tx_state); end
        n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        n_vec++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
        n_vec++; if (rx_state !== 1'b0) begin n_err++; $display("FAIL reset_rx_state: got %b want 0", rx_state); end
        reset_n = 1'b1;
        ticks(5);
    endtask

    task automatic test_single_frame();
        logic [7:0]  d = 8'hAA;
        logic [9:0]  fr;
        int unsigned slot_ok[10];
        int unsigned state_hi    = 0;
        int unsigned done_at     = 0;
        int unsigned done_pulses = 0;
        logic        line0;
        logic        state_at_end = 1'b1;
        fr = frame_bits(d, 1'b1);
        rx_q.delete();
        for (int i = 0; i < 10; i++) slot_ok[i] = 0;
        pulse_start(d);
        line0 = rs232_tx;
        if (tx_state === 1'b1) state_hi++;
        for (int unsigned k = 1; k <= FRAME_T + 1; k++) begin
            if (k % 97 == 0) tx_data = 8'($urandom);
            tick();
            if (k <= FRAME_T && rs232_tx === fr[(k - 1) / BIT_T]) slot_ok[(k - 1) / BIT_T]++;
            if (k < FRAME_T && tx_state === 1'b1) state_hi++;
            if (k == FRAME_T) state_at_end = tx_state;
            if (tx_done === 1'b1) begin
                done_pulses++;
                done_at = k;
            end
        end
        n_vec++; if (line0 !== 1'b1) begin n_err++; $display("FAIL single_line_at_start_edge: got %b want 1", line0); end
        for (int s = 0; s < 10; s++) begin
            n_vec++;
            if (slot_ok[s] != BIT_T) begin
                n_err++;
                $display("FAIL single_slot%0d: %0d cycles at level %b, want %0d", s, slot_ok[s], fr[s], BIT_T);
            end
        end
        n_vec++; if (done_at != FRAME_T) begin n_err++; $display("FAIL single_done_latency: got %0d want %0d", done_at, FRAME_T); end
        n_vec++; if (done_pulses != 1) begin n_err++; $display("FAIL single_done_pulses: got %0d want 1", done_pulses); end
        n_vec++; if (state_hi != FRAME_T) begin n_err++; $display("FAIL single_tx_state_high: got %0d want %0d", state_hi, FRAME_T); end
        n_vec++; if (state_at_end !== 1'b0) begin n_err++; $display("FAIL single_tx_state_end: got %b want 0", state_at_end); end
        wait_rx_count(1, 2 * BIT_T);
        n_vec++;
        if (rx_q.size() != 1 || rx_q[0] !== d) begin
            n_err++;
            $display("FAIL single_loopback_rx: got %0d bytes first %h want 1 byte %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, d);
        end
        exp_rx_data = d;
        ticks(10);
    endtask

    task automatic test_ignore_restart();
        logic [7:0]  d;
        int unsigned base;
        int unsigned waited;
        bit          seen;
        d = 8'($urandom);
        rx_q.delete();
        base = tx_done_cnt;
        pulse_start(d);
        ticks(999);
        tx_data  = ~d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        wait_tx_done(FRAME_T, waited, seen);
        ticks(2 * BIT_T);
        n_vec++; if (!seen || waited != FRAME_T - 1000) begin n_err++; $display("FAIL restart_done_latency: seen %0d after %0d want %0d", seen, waited, FRAME_T - 1000); end
        n_vec++; if (tx_done_cnt - base != 1) begin n_err++; $display("FAIL restart_done_pulses: got %0d want 1", tx_done_cnt - base); end
        n_vec++; if (tx_state !== 1'b0) begin n_err++; $display("FAIL restart_tx_idle: got %b want 0", tx_state); end
        n_vec++;
        if (rx_q.size() != 1 || rx_q[0] !== d) begin
            n_err++;
            $display("FAIL restart_rx_byte: got %0d bytes first %h want 1 byte %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, d);
        end
        exp_rx_data = d;
    endtask

    task automatic test_loopback_b2b();
        logic [7:0]  bytes[4] = '{8'hC2, 8'hB3, 8'hA4, 8'h95};
        int unsigned waited;
        int unsigned want;
        bit          seen;
        rx_q.delete();
        pulse_start(bytes[0]);
        for (int i = 0; i < 4; i++) begin
            want = (i == 0) ? FRAME_T : FRAME_T - 1;
            wait_tx_done(FRAME_T + 10, waited, seen);
            n_vec++;
            if (!seen || waited != want) begin
                n_err++;
                $display("FAIL b2b_done%0d: seen %0d after %0d want %0d", i, seen, waited, want);
            end
            if (i < 3) begin
                tx_data  = bytes[i + 1];
                tx_start = 1'b1;
                tick();
                tx_start = 1'b0;
                tick();
                n_vec++;
                if (rs232_tx !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_gapless%0d: line %b two cycles after tx_done, want 0", i, rs232_tx);
                end
            end
        end
        wait_rx_count(4, 2 * BIT_T);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rx_q.size() <= i || rx_q[i] !== bytes[i]) begin
                n_err++;
                $display("FAIL b2b_rx%0d: got %h want %h (%0d bytes)", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, bytes[i], rx_q.size());
            end
        end
        exp_rx_data = bytes[3];
        ticks(10);
    endtask

    task automatic test_random_loopback();
        logic [7:0]  exp_q[$];
        int unsigned waited;
        bit          seen;
        rx_q.delete();
        for (int i = 0; i < 3; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            exp_q.push_back(d);
            ticks($urandom_range(0, 40));
            pulse_start(d);
            wait_tx_done(FRAME_T + 10, waited, seen);
            n_vec++;
            if (!seen) begin n_err++; $display("FAIL rand_done%0d: no tx_done within %0d cycles", i, FRAME_T + 10); end
        end
        wait_rx_count(3, 2 * BIT_T);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (rx_q.size() <= i || rx_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rand_rx%0d: got %h want %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_q[i]);
            end
        end
        exp_rx_data = exp_q[2];
        ticks(10);
    endtask

    task automatic test_rx_glitch();
        bit saw_busy = 1'b0;
        loopback = 1'b0;
        rx_drv   = 1'b1;
        ticks(5);
        rx_q.delete();
        rx_drv = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rx_state === 1'b1) saw_busy = 1'b1;
        end
        rx_drv = 1'b1;
        for (int unsigned i = 0; i < BIT_T; i++) begin
            tick();
            if (rx_state === 1'b1) saw_busy = 1'b1;
        end
        n_vec++; if (saw_busy != 1'b1) begin n_err++; $display("FAIL glitch_rx_state_pulse: got %b want 1", saw_busy); end
        n_vec++; if (rx_state !== 1'b0) begin n_err++; $display("FAIL glitch_rx_state_end: got %b want 0", rx_state); end
        n_vec++; if (rx_q.size() != 0) begin n_err++; $display("FAIL glitch_no_rx_done: got %0d pulses want 0", rx_q.size()); end
        n_vec++; if (rx_data !== exp_rx_data) begin n_err++; $display("FAIL glitch_rx_data: got %h want %h", rx_data, exp_rx_data); end
    endtask

    task automatic test_rx_frame_error();
        logic [7:0] d1;
        logic [7:0] d2;
        loopback = 1'b0;
        rx_q.delete();
        drive_rx_frame(8'h55, 1'b0);
        ticks(2 * BIT_T);
        n_vec++; if (rx_q.size() != 0) begin n_err++; $display("FAIL ferr_no_rx_done: got %0d pulses want 0", rx_q.size()); end
        n_vec++; if (rx_data !== exp_rx_data) begin n_err++; $display("FAIL ferr_rx_data_held: got %h want %h", rx_data, exp_rx_data); end
        drive_rx_frame(8'h3C, 1'b1);
        ticks(BIT_T);
        n_vec++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h3C || rx_data !== 8'h3C) begin
            n_err++;
            $display("FAIL ferr_recover: %0d bytes, rx_data %h want 1 byte 3c", rx_q.size(), rx_data);
        end
        // Two frames with no idle between them: the second start follows the stop directly.
        rx_q.delete();
        d1 = 8'($urandom_range(1, 255));
        d2 = 8'($urandom_range(1, 255));
        drive_rx_frame(d1, 1'b1);
        drive_rx_frame(d2, 1'b1);
        ticks(BIT_T);
        n_vec++;
        if (rx_q.size() != 2 || rx_q[0] !== d1 || rx_q[1] !== d2) begin
            n_err++;
            $display("FAIL rx_back_to_back: got %0d bytes want %h %h", rx_q.size(), d1, d2);
        end
        exp_rx_data = d2;
        loopback = 1'b1;
        ticks(5);
    endtask

    task automatic test_mid_frame_reset();
        logic [7:0]  d;
        int unsigned waited;
        bit          seen;
        loopback = 1'b1;
        rx_q.delete();
        d = 8'($urandom);
        pulse_start(d);
        ticks(2000);
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (rs232_tx !== 1'b1) begin n_err++; $display("FAIL mreset_rs232_tx: got %b want 1", rs232_tx); end
        n_vec++; if (tx_state !== 1'b0) begin n_err++; $display("FAIL mreset_tx_state: got %b want 0", tx_state); end
        n_vec++; if (rx_state !== 1'b0) begin n_err++; $display("FAIL mreset_rx_state: got %b want 0", rx_state); end
        n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL mreset_rx_data: got %h want 00", rx_data); end
        ticks(3);
        reset_n = 1'b1;
        ticks(3);
        exp_rx_data = 8'h00;
        n_vec++; if (rx_q.size() != 0) begin n_err++; $display("FAIL mreset_aborted_rx: got %0d bytes want 0", rx_q.size()); end
        d = 8'($urandom);
        pulse_start(d);
        wait_tx_done(FRAME_T + 10, waited, seen);
        n_vec++; if (!seen || waited != FRAME_T) begin n_err++; $display("FAIL mreset_next_done: seen %0d after %0d want %0d", seen, waited, FRAME_T); end
        wait_rx_count(1, 2 * BIT_T);
        n_vec++;
        if (rx_q.size() != 1 || rx_q[0] !== d) begin
            n_err++;
            $display("FAIL mreset_next_rx: got %0d bytes first %h want %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, d);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_ignore_restart();
        test_loopback_b2b();
        test_random_loopback();
        test_rx_glitch();
        test_rx_frame_error();
        test_mid_frame_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
